// File: rtl/llrb_replay_ctrl.sv
// llrb_replay_ctrl: pointer/occupancy controller and replay sequencer for the
// link-layer retry buffer. It holds no flit data. It only drives the address and
// enables of an external LLRB RAM.
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_llr_wrap_value          last valid slot index; depth D = wrap + 1
//   i_tx_flit_valid           new flit offered; o_tx_ready / o_buf_wr_en / o_buf_wr_addr
//   i_ack_valid, i_ack_num    Full_Ack from the unpacker (frees i_ack_num oldest slots)
//   i_replay_req, i_replay_eseq  RETRY.REQ from the unpacker
//   i_replay_ready            TX mux accepts a replay read; o_buf_rd_en / o_buf_rd_addr
//   o_replaying, o_replay_done, o_seq_err  status / 1-cycle pulses
//   o_wrt_ptr, o_num_free_buff, o_buf_consumed  reported to the control-flit packer
module llrb_replay_ctrl #(
  parameter int unsigned PTR_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [PTR_W-1:0] i_llr_wrap_value,
  input  logic             i_tx_flit_valid,
  output logic             o_tx_ready,
  output logic             o_buf_wr_en,
  output logic [PTR_W-1:0] o_buf_wr_addr,
  input  logic             i_ack_valid,
  input  logic [PTR_W-1:0] i_ack_num,
  input  logic             i_replay_req,
  input  logic [PTR_W-1:0] i_replay_eseq,
  input  logic             i_replay_ready,
  output logic             o_buf_rd_en,
  output logic [PTR_W-1:0] o_buf_rd_addr,
  output logic             o_replaying,
  output logic             o_replay_done,
  output logic             o_seq_err,
  output logic [PTR_W-1:0] o_wrt_ptr,
  output logic [PTR_W-1:0] o_num_free_buff,
  output logic [PTR_W-1:0] o_buf_consumed
);

  localparam int unsigned CW = PTR_W + 1;

  typedef enum logic [0:0] {StIdle, StReplay} state_e;

  state_e           state_q;
  logic [PTR_W-1:0] wr_ptr_q, tail_q, rd_ptr_q;
  logic [CW-1:0]    count_q, remaining_q;
  logic             done_q, seq_err_q;

  logic [CW-1:0] depth, eseq_ext, tail_ext, ack_ext, off, rep_remaining, count_nx;
  logic [CW-1:0] free_raw, tail_sum;
  logic          wr, rep_ok, rep_take, rep_bad, ack_ok, ack_take, ack_bad, rd_en;

  // Modular pointer increment within 0..wrap.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p,
                                               input logic [PTR_W-1:0] wrap);
    return (p == wrap) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    depth    = {1'b0, i_llr_wrap_value} + 1'b1;
    eseq_ext = {1'b0, i_replay_eseq};
    tail_ext = {1'b0, tail_q};
    ack_ext  = {1'b0, i_ack_num};

    o_tx_ready = (state_q == StIdle) && (count_q < depth);
    wr         = o_tx_ready & i_tx_flit_valid;

    // Distance from oldest unacked entry to the requested ESEQ, modulo D.
    if (eseq_ext >= tail_ext) off = eseq_ext - tail_ext;
    else                      off = eseq_ext + depth - tail_ext;
    // An ESEQ beyond the wrap value can never name a slot.
    rep_ok        = (eseq_ext < depth) && (off <= count_q);
    rep_take      = i_replay_req & rep_ok;
    rep_bad       = i_replay_req & ~rep_ok;
    rep_remaining = count_q - off;

    // A legal replay request's implicit ack supersedes a same-cycle Full_Ack.
    ack_ok   = ack_ext <= count_q;
    ack_take = i_ack_valid & ~rep_take & ack_ok;
    ack_bad  = i_ack_valid & ~rep_take & ~ack_ok;

    tail_sum = tail_ext + ack_ext;
    if (tail_sum >= depth) tail_sum = tail_sum - depth;

    count_nx = count_q + CW'(wr);
    if (rep_take)      count_nx = count_nx - off;
    else if (ack_take) count_nx = count_nx - ack_ext;

    rd_en = (state_q == StReplay) && i_replay_ready && (remaining_q != '0);

    free_raw = depth - count_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      tail_q      <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      remaining_q <= '0;
      done_q      <= 1'b0;
      seq_err_q   <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      seq_err_q <= rep_bad | ack_bad;
      count_q   <= count_nx;
      if (wr) wr_ptr_q <= ptr_inc(wr_ptr_q, i_llr_wrap_value);

      if (rep_take)      tail_q <= i_replay_eseq;
      else if (ack_take) tail_q <= tail_sum[PTR_W-1:0];

      // A legal request (re)starts the replay, even mid-replay.
      if (rep_take) begin
        rd_ptr_q    <= i_replay_eseq;
        remaining_q <= rep_remaining;
        if (rep_remaining == '0) begin
          state_q <= StIdle;
          done_q  <= 1'b1;
        end else begin
          state_q <= StReplay;
        end
      end else if (rd_en) begin
        rd_ptr_q    <= ptr_inc(rd_ptr_q, i_llr_wrap_value);
        remaining_q <= remaining_q - 1'b1;
        if (remaining_q == CW'(1)) begin
          state_q <= StIdle;
          done_q  <= 1'b1;
        end
      end
    end
  end

  assign o_buf_wr_en     = wr;
  assign o_buf_wr_addr   = wr_ptr_q;
  assign o_buf_rd_en     = rd_en;
  assign o_buf_rd_addr   = rd_ptr_q;
  assign o_replaying     = (state_q == StReplay);
  assign o_replay_done   = done_q;
  assign o_seq_err       = seq_err_q;
  assign o_wrt_ptr       = wr_ptr_q;
  // Depth can be 2**PTR_W, which does not fit the report field; saturate.
  assign o_num_free_buff = free_raw[PTR_W] ? '1 : free_raw[PTR_W-1:0];
  assign o_buf_consumed  = count_q[PTR_W] ? '1 : count_q[PTR_W-1:0];

endmodule

// File: tb/tb_llrb_replay_ctrl.sv
// Directed bench for llrb_replay_ctrl: fill/wrap, ack, replay, ready gaps,
// illegal ack/eseq, replay restart and reset during replay.
module tb_llrb_replay_ctrl;

  localparam int unsigned PTR_W = 8;

  logic             i_clk = 1'b0;
  logic             i_rst_n;
  logic [PTR_W-1:0] i_llr_wrap_value;
  logic             i_tx_flit_valid;
  logic             o_tx_ready;
  logic             o_buf_wr_en;
  logic [PTR_W-1:0] o_buf_wr_addr;
  logic             i_ack_valid;
  logic [PTR_W-1:0] i_ack_num;
  logic             i_replay_req;
  logic [PTR_W-1:0] i_replay_eseq;
  logic             i_replay_ready;
  logic             o_buf_rd_en;
  logic [PTR_W-1:0] o_buf_rd_addr;
  logic             o_replaying;
  logic             o_replay_done;
  logic             o_seq_err;
  logic [PTR_W-1:0] o_wrt_ptr;
  logic [PTR_W-1:0] o_num_free_buff;
  logic [PTR_W-1:0] o_buf_consumed;

  int n_checks = 0;
  int n_errors = 0;

  llrb_replay_ctrl #(.PTR_W(PTR_W)) dut (
    .i_clk            (i_clk),
    .i_rst_n          (i_rst_n),
    .i_llr_wrap_value (i_llr_wrap_value),
    .i_tx_flit_valid  (i_tx_flit_valid),
    .o_tx_ready       (o_tx_ready),
    .o_buf_wr_en      (o_buf_wr_en),
    .o_buf_wr_addr    (o_buf_wr_addr),
    .i_ack_valid      (i_ack_valid),
    .i_ack_num        (i_ack_num),
    .i_replay_req     (i_replay_req),
    .i_replay_eseq    (i_replay_eseq),
    .i_replay_ready   (i_replay_ready),
    .o_buf_rd_en      (o_buf_rd_en),
    .o_buf_rd_addr    (o_buf_rd_addr),
    .o_replaying      (o_replaying),
    .o_replay_done    (o_replay_done),
    .o_seq_err        (o_seq_err),
    .o_wrt_ptr        (o_wrt_ptr),
    .o_num_free_buff  (o_num_free_buff),
    .o_buf_consumed   (o_buf_consumed)
  );

  always #5 i_clk = ~i_clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    i_rst_n          = 1'b0;
    i_llr_wrap_value = 8'd7;
    i_tx_flit_valid  = 1'b0;
    i_ack_valid      = 1'b0;
    i_ack_num        = '0;
    i_replay_req     = 1'b0;
    i_replay_eseq    = '0;
    i_replay_ready   = 1'b0;

    // 1: reset values, then fill 8 slots and refuse the 9th
    #12;
    check_eq("rst_tx_ready", o_tx_ready, 1);
    check_eq("rst_free", o_num_free_buff, 8);
    check_eq("rst_consumed", o_buf_consumed, 0);
    check_eq("rst_wrt_ptr", o_wrt_ptr, 0);
    check_eq("rst_replaying", o_replaying, 0);
    check_eq("rst_done", o_replay_done, 0);
    check_eq("rst_seq_err", o_seq_err, 0);
    check_eq("rst_rd_en", o_buf_rd_en, 0);
    tick();
    i_rst_n = 1'b1;
    i_tx_flit_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      check_eq("t1_wr_en", o_buf_wr_en, 1);
      check_eq("t1_wr_addr", o_buf_wr_addr, i);
      tick();
    end
    #1;
    check_eq("t1_full_ready", o_tx_ready, 0);
    check_eq("t1_9th_wr_en", o_buf_wr_en, 0);
    check_eq("t1_free", o_num_free_buff, 0);
    check_eq("t1_consumed", o_buf_consumed, 8);
    check_eq("t1_wrt_ptr", o_wrt_ptr, 0);
    i_tx_flit_valid = 1'b0;

    // 2: ack 3 (tail 3), then 3 writes wrap to addrs 0,1,2
    i_ack_valid = 1'b1;
    i_ack_num   = 8'd3;
    tick();
    i_ack_valid = 1'b0;
    i_ack_num   = '0;
    #1;
    check_eq("t2_free", o_num_free_buff, 3);
    check_eq("t2_consumed", o_buf_consumed, 5);
    check_eq("t2_tx_ready", o_tx_ready, 1);
    i_tx_flit_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("t2_wr_en", o_buf_wr_en, 1);
      check_eq("t2_wr_addr", o_buf_wr_addr, i);
      tick();
    end
    i_tx_flit_valid = 1'b0;
    #1;
    check_eq("t2_wrt_ptr", o_wrt_ptr, 3);
    check_eq("t2_free_full", o_num_free_buff, 0);

    // 3: ack 3 -> tail 6, count 5; replay eseq 0 -> count 3, reads 0,1,2
    i_ack_valid = 1'b1;
    i_ack_num   = 8'd3;
    tick();
    i_ack_valid = 1'b0;
    i_ack_num   = '0;
    #1;
    check_eq("t3_consumed5", o_buf_consumed, 5);
    i_replay_req   = 1'b1;
    i_replay_eseq  = 8'd0;
    i_replay_ready = 1'b1;
    #1;
    check_eq("t3_no_rd_in_idle", o_buf_rd_en, 0);
    tick();
    i_replay_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("t3_replaying", o_replaying, 1);
      check_eq("t3_tx_ready", o_tx_ready, 0);
      check_eq("t3_rd_en", o_buf_rd_en, 1);
      check_eq("t3_rd_addr", o_buf_rd_addr, i);
      check_eq("t3_done_early", o_replay_done, 0);
      tick();
    end
    #1;
    check_eq("t3_done", o_replay_done, 1);
    check_eq("t3_idle", o_replaying, 0);
    check_eq("t3_rd_en_off", o_buf_rd_en, 0);
    check_eq("t3_consumed3", o_buf_consumed, 3);
    tick();
    #1;
    check_eq("t3_done_pulse", o_replay_done, 0);

    // 4: one more write (addr 3) -> count 4; replay from 0 with ready toggling
    i_tx_flit_valid = 1'b1;
    #1;
    check_eq("t4_wr_addr", o_buf_wr_addr, 3);
    tick();
    i_tx_flit_valid = 1'b0;
    i_replay_req    = 1'b1;
    i_replay_eseq   = 8'd0;
    i_replay_ready  = 1'b0;
    tick();
    i_replay_req    = 1'b0;
    i_tx_flit_valid = 1'b1;
    for (int k = 0; k < 7; k++) begin
      i_replay_ready = (k % 2 == 0);
      #1;
      check_eq("t4_rd_en", o_buf_rd_en, (k % 2 == 0));
      if (k % 2 == 0) check_eq("t4_rd_addr", o_buf_rd_addr, k / 2);
      check_eq("t4_tx_ready", o_tx_ready, 0);
      check_eq("t4_no_write", o_buf_wr_en, 0);
      check_eq("t4_done_early", o_replay_done, 0);
      tick();
    end
    i_tx_flit_valid = 1'b0;
    i_replay_ready  = 1'b0;
    #1;
    check_eq("t4_done", o_replay_done, 1);
    check_eq("t4_idle", o_replaying, 0);
    check_eq("t4_consumed", o_buf_consumed, 4);
    check_eq("t4_wrt_ptr", o_wrt_ptr, 4);
    tick();

    // 5: ack 2 -> count 2, tail 2; illegal ack 3; illegal eseq 6; eseq 4 empties
    i_ack_valid = 1'b1;
    i_ack_num   = 8'd2;
    tick();
    #1;
    check_eq("t5_consumed2", o_buf_consumed, 2);
    i_ack_num = 8'd3;
    #1;
    check_eq("t5_err_not_yet", o_seq_err, 0);
    tick();
    i_ack_valid = 1'b0;
    i_ack_num   = '0;
    #1;
    check_eq("t5_ack_err", o_seq_err, 1);
    check_eq("t5_count_kept", o_buf_consumed, 2);
    tick();
    #1;
    check_eq("t5_err_pulse", o_seq_err, 0);
    i_replay_req  = 1'b1;
    i_replay_eseq = 8'd6;
    tick();
    i_replay_req = 1'b0;
    #1;
    check_eq("t5_eseq_err", o_seq_err, 1);
    check_eq("t5_eseq_idle", o_replaying, 0);
    check_eq("t5_eseq_count", o_buf_consumed, 2);
    tick();
    i_replay_req  = 1'b1;
    i_replay_eseq = 8'd4;
    tick();
    i_replay_req = 1'b0;
    #1;
    check_eq("t5_empty_done", o_replay_done, 1);
    check_eq("t5_empty_idle", o_replaying, 0);
    check_eq("t5_empty_count", o_buf_consumed, 0);
    check_eq("t5_empty_free", o_num_free_buff, 8);
    check_eq("t5_empty_no_err", o_seq_err, 0);
    tick();
    #1;
    check_eq("t5_done_pulse", o_replay_done, 0);

    // 6: write addrs 4..7, replay from 4, restart at 6th read, then reset mid-replay
    i_tx_flit_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq("t6_wr_addr", o_buf_wr_addr, 4 + i);
      tick();
    end
    i_tx_flit_valid = 1'b0;
    #1;
    check_eq("t6_wrt_ptr", o_wrt_ptr, 0);
    i_replay_req   = 1'b1;
    i_replay_eseq  = 8'd4;
    i_replay_ready = 1'b1;
    tick();
    i_replay_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      check_eq("t6_rd_addr", o_buf_rd_addr, 4 + i);
      tick();
    end
    i_replay_req  = 1'b1;
    i_replay_eseq = 8'd4;
    #1;
    check_eq("t6_rd_addr6", o_buf_rd_addr, 6);
    tick();
    i_replay_req = 1'b0;
    #1;
    check_eq("t6_restart_addr", o_buf_rd_addr, 4);
    check_eq("t6_restart_replaying", o_replaying, 1);
    check_eq("t6_restart_no_done", o_replay_done, 0);
    check_eq("t6_restart_count", o_buf_consumed, 4);
    tick();
    #1;
    check_eq("t6_restart_addr5", o_buf_rd_addr, 5);
    i_rst_n = 1'b0;
    #1;
    check_eq("t6_rst_replaying", o_replaying, 0);
    check_eq("t6_rst_rd_en", o_buf_rd_en, 0);
    check_eq("t6_rst_consumed", o_buf_consumed, 0);
    check_eq("t6_rst_free", o_num_free_buff, 8);
    check_eq("t6_rst_wrt_ptr", o_wrt_ptr, 0);
    check_eq("t6_rst_tx_ready", o_tx_ready, 1);
    tick();
    i_rst_n        = 1'b1;
    i_replay_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("t6_rst_no_done", o_replay_done, 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
